// File: rtl/memory_pkg.sv
// Shared definitions for the read-side line splitter: FSM encoding, line size
// and a byte-lane mask helper.
package memory_pkg;

   localparam int LINE_BYTES = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FIRST  = 2'd1,
      ST_SECOND = 2'd2,
      ST_DONE   = 2'd3
   } rd_state_e;

   // Mask covering the lowest nbytes byte lanes of a 64-bit word (nbytes 0..8).
   function automatic logic [63:0] byte_mask(input logic [3:0] nbytes);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < int'(nbytes)) m[8*i +: 8] = 8'hFF;
      end
      return m;
   endfunction

endpackage

// File: rtl/read_byte_merge.sv
// Combinational byte-lane merge of two line parts into one little-endian word.
// Shared with the write-side splitter.
module read_byte_merge
   import memory_pkg::*;
(
   input  logic [63:0] buf_i,
   input  logic [63:0] part2_i,
   input  logic [3:0]  len1_i,
   input  logic [3:0]  len2_i,
   output logic [63:0] merged_o
);

   logic [63:0] part2_masked;
   logic [6:0]  shift_bits;

   always_comb begin
      part2_masked = part2_i & byte_mask(len2_i);
      shift_bits   = {len1_i, 3'b000};
      merged_o     = (buf_i & byte_mask(len1_i)) | (part2_masked << shift_bits);
   end

endmodule

// File: rtl/tlbread_line_split.sv
// Splits a read into at most two 16-byte-line accesses and merges the result.
// Line splitting is built only when TLBREAD_LINE_SPLIT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a request; clears abort
// FIRST  | first (or only) part outstanding downstream
// SECOND | second part, starting at the next line, outstanding
// DONE   | completion pulse cycle; request input ignored
module tlbread_line_split
   import memory_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rd_reset,
   input  logic        tlbread_do,
   input  logic [1:0]  tlbread_cpl,
   input  logic        tlbread_lock,
   input  logic        tlbread_rmw,
   input  logic [31:0] tlbread_address,
   input  logic [3:0]  tlbread_length,
   output logic        tlbread_done,
   output logic        tlbread_page_fault,
   output logic        tlbread_ac_fault,
   output logic        tlbread_retry,
   output logic [63:0] tlbread_data,
   output logic        dcread_do,
   output logic [1:0]  dcread_cpl,
   output logic        dcread_lock,
   output logic        dcread_rmw,
   output logic [31:0] dcread_address,
   output logic [3:0]  dcread_length,
   output logic [3:0]  dcread_length_full,
   input  logic        dcread_done,
   input  logic        dcread_page_fault,
   input  logic        dcread_ac_fault,
   input  logic        dcread_retry,
   input  logic [63:0] dcread_data
);

   rd_state_e   state_q;
   logic        abort_q, done_q, pf_q, ac_q, retry_q, dc_do_q, lock_q, rmw_q;
   logic [1:0]  cpl_q;
   logic [31:0] dc_addr_q;
   logic [3:0]  dc_len_q, full_q;
   logic [63:0] data_q;
   logic [3:0]  len1_c;

`ifdef TLBREAD_LINE_SPLIT_EN
   logic [4:0]  left_c;
   logic [3:0]  len2_c, len1_q, len2_q;
   logic [31:0] addr2_c, addr2_q;
   logic [63:0] buf_q, merged_c;

   assign left_c  = 5'(LINE_BYTES) - {1'b0, tlbread_address[3:0]};
   assign len1_c  = ({1'b0, tlbread_length} < left_c) ? tlbread_length : left_c[3:0];
   assign len2_c  = tlbread_length - len1_c;
   assign addr2_c = {tlbread_address[31:4], 4'd0} + 32'(LINE_BYTES);

   read_byte_merge u_merge (
      .buf_i    (buf_q),
      .part2_i  (dcread_data),
      .len1_i   (len1_q),
      .len2_i   (len2_q),
      .merged_o (merged_c)
   );
`else
   assign len1_c = tlbread_length;
`endif

   logic ev_fault, ev_any, abort_now;
   assign ev_fault  = dcread_page_fault | dcread_ac_fault;
   assign ev_any    = ev_fault | dcread_retry | dcread_done;
   assign abort_now = abort_q | rd_reset;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         abort_q   <= 1'b0;
         done_q    <= 1'b0;
         pf_q      <= 1'b0;
         ac_q      <= 1'b0;
         retry_q   <= 1'b0;
         dc_do_q   <= 1'b0;
         lock_q    <= 1'b0;
         rmw_q     <= 1'b0;
         cpl_q     <= 2'd0;
         dc_addr_q <= 32'd0;
         dc_len_q  <= 4'd0;
         full_q    <= 4'd0;
         data_q    <= 64'd0;
`ifdef TLBREAD_LINE_SPLIT_EN
         len1_q    <= 4'd0;
         len2_q    <= 4'd0;
         addr2_q   <= 32'd0;
         buf_q     <= 64'd0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               abort_q <= 1'b0;
               if (tlbread_do && !rd_reset) begin
                  state_q   <= ST_FIRST;
                  dc_do_q   <= 1'b1;
                  dc_addr_q <= tlbread_address;
                  dc_len_q  <= len1_c;
                  full_q    <= tlbread_length;
                  cpl_q     <= tlbread_cpl;
                  lock_q    <= tlbread_lock;
                  rmw_q     <= tlbread_rmw;
`ifdef TLBREAD_LINE_SPLIT_EN
                  len1_q    <= len1_c;
                  len2_q    <= len2_c;
                  addr2_q   <= addr2_c;
`endif
               end
            end
            ST_FIRST, ST_SECOND: begin
               if (rd_reset) abort_q <= 1'b1;
               if (ev_any) begin
                  // An aborted request finishes its outstanding part silently.
                  dc_do_q <= 1'b0;
                  state_q <= abort_now ? ST_IDLE : ST_DONE;
                  if (ev_fault) begin
                     pf_q <= !abort_now && dcread_page_fault;
                     ac_q <= !abort_now && dcread_ac_fault;
                  end else if (dcread_retry) begin
                     retry_q <= !abort_now;
                  end else if (!abort_now) begin
`ifdef TLBREAD_LINE_SPLIT_EN
                     if (state_q == ST_FIRST && len2_q != 4'd0) begin
                        buf_q     <= dcread_data;
                        state_q   <= ST_SECOND;
                        dc_do_q   <= 1'b1;
                        dc_addr_q <= addr2_q;
                        dc_len_q  <= len2_q;
                     end else begin
                        done_q <= 1'b1;
                        data_q <= (state_q == ST_FIRST) ?
                                  (dcread_data & byte_mask(dc_len_q)) : merged_c;
                     end
`else
                     done_q <= 1'b1;
                     data_q <= dcread_data & byte_mask(dc_len_q);
`endif
                  end
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               pf_q    <= 1'b0;
               ac_q    <= 1'b0;
               retry_q <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign tlbread_done       = done_q;
   assign tlbread_page_fault = pf_q;
   assign tlbread_ac_fault   = ac_q;
   assign tlbread_retry      = retry_q;
   assign tlbread_data       = data_q;
   assign dcread_do          = dc_do_q;
   assign dcread_cpl         = cpl_q;
   assign dcread_lock        = lock_q;
   assign dcread_rmw         = rmw_q;
   assign dcread_address     = dc_addr_q;
   assign dcread_length      = dc_len_q;
   assign dcread_length_full = full_q;

endmodule

// File: tb/tb_tlbread_line_split.sv
// Scoreboard bench for tlbread_line_split: random reads against a byte-addressed
// memory model, with a downstream responder and an upstream completion monitor.
module tb_tlbread_line_split;

`ifdef TLBREAD_LINE_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, rd_reset, tlbread_do, tlbread_lock, tlbread_rmw;
   logic [1:0]  tlbread_cpl;
   logic [31:0] tlbread_address;
   logic [3:0]  tlbread_length;
   logic        tlbread_done, tlbread_page_fault, tlbread_ac_fault, tlbread_retry;
   logic [63:0] tlbread_data;
   logic        dcread_do, dcread_lock, dcread_rmw;
   logic [1:0]  dcread_cpl;
   logic [31:0] dcread_address;
   logic [3:0]  dcread_length, dcread_length_full;
   logic        dcread_done = 0, dcread_page_fault = 0, dcread_ac_fault = 0, dcread_retry = 0;
   logic [63:0] dcread_data = '0;

   tlbread_line_split dut (
      .clk(clk), .rst_n(rst_n), .rd_reset(rd_reset), .tlbread_do(tlbread_do),
      .tlbread_cpl(tlbread_cpl), .tlbread_lock(tlbread_lock), .tlbread_rmw(tlbread_rmw),
      .tlbread_address(tlbread_address), .tlbread_length(tlbread_length),
      .tlbread_done(tlbread_done), .tlbread_page_fault(tlbread_page_fault),
      .tlbread_ac_fault(tlbread_ac_fault), .tlbread_retry(tlbread_retry),
      .tlbread_data(tlbread_data), .dcread_do(dcread_do), .dcread_cpl(dcread_cpl),
      .dcread_lock(dcread_lock), .dcread_rmw(dcread_rmw), .dcread_address(dcread_address),
      .dcread_length(dcread_length), .dcread_length_full(dcread_length_full),
      .dcread_done(dcread_done), .dcread_page_fault(dcread_page_fault),
      .dcread_ac_fault(dcread_ac_fault), .dcread_retry(dcread_retry),
      .dcread_data(dcread_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  len, full;
      logic [1:0]  cpl;
      logic        lock, rmw;
      int          outcome;   // 0 done, 1 page fault, 2 ac fault, 3 retry
      bit          last, abort;
      int          lat;
      logic [63:0] data;
   } part_t;

   typedef struct {
      int          kind;
      logic [63:0] data;
   } resp_t;

   part_t part_q[$];
   resp_t resp_q[$];
   int    cyc_q[$];
   int    checks = 0, errors = 0;
   int    cyc = 0;
   int    txn_end_cnt = 0, n_issued = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] mb(input logic [31:0] a, input logic [7:0] s);
      return (a[7:0] * 8'd37) ^ a[15:8] ^ s;
   endfunction

   function automatic logic [63:0] bytes_at(input logic [31:0] a, input int n, input logic [7:0] s);
      logic [63:0] d;
      d = '0;
      for (int k = 0; k < n; k++) d[8*k +: 8] = mb(a + 32'(k), s);
      return d;
   endfunction

   // Downstream responder: checks each part request and answers after its latency.
   initial begin
      part_t cur;
      int    cnt = 0;
      bit    busy = 0;
      forever begin
         @(negedge clk);
         dcread_done = 0; dcread_page_fault = 0; dcread_ac_fault = 0; dcread_retry = 0;
         dcread_data = '0;
         if (!rst_n) begin
            busy = 0;
         end else begin
            if (!busy && dcread_do) begin
               checks++;
               if (part_q.size() == 0) begin
                  errors++;
                  $display("FAIL dc_unexpected: access addr=%h len=%0d, required no access",
                           dcread_address, dcread_length);
               end else begin
                  cur = part_q.pop_front();
                  if ({dcread_address, dcread_length, dcread_length_full, dcread_cpl, dcread_lock, dcread_rmw} !==
                      {cur.addr, cur.len, cur.full, cur.cpl, cur.lock, cur.rmw}) begin
                     errors++;
                     $display("FAIL dc_req: got addr=%h len=%0d full=%0d cpl=%0d lock=%b rmw=%b, required addr=%h len=%0d full=%0d cpl=%0d lock=%b rmw=%b",
                              dcread_address, dcread_length, dcread_length_full, dcread_cpl, dcread_lock, dcread_rmw,
                              cur.addr, cur.len, cur.full, cur.cpl, cur.lock, cur.rmw);
                  end
                  busy = 1;
                  cnt  = cur.lat;
               end
            end
            if (busy) begin
               if (cnt == 0) begin
                  case (cur.outcome)
                     1:       dcread_page_fault = 1;
                     2:       dcread_ac_fault = 1;
                     3:       dcread_retry = 1;
                     default: begin dcread_done = 1; dcread_data = cur.data; end
                  endcase
                  busy = 0;
                  if (cur.last) begin
                     txn_end_cnt++;
                     if (!cur.abort) cyc_q.push_back(cyc + 1);
                  end
               end else begin
                  cnt--;
               end
            end
         end
      end
   end

   // Upstream monitor: every completion pulse is matched against the scoreboard.
   initial begin
      resp_t     r;
      int        c;
      logic [3:0] got, want;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            got = {tlbread_done, tlbread_page_fault, tlbread_ac_fault, tlbread_retry};
            if (got != 4'b0000) begin
               checks++;
               if (resp_q.size() == 0 || cyc_q.size() == 0) begin
                  errors++;
                  $display("FAIL up_unexpected: pulses done/pf/ac/retry=%b, required none", got);
               end else begin
                  r = resp_q.pop_front();
                  c = cyc_q.pop_front();
                  want = 4'b1000 >> r.kind;
                  if (got !== want || cyc != c || (r.kind == 0 && tlbread_data !== r.data)) begin
                     errors++;
                     $display("FAIL up_resp: got pulses=%b cycle=%0d data=%h, required pulses=%b cycle=%0d data=%h",
                              got, cyc, tlbread_data, want, c, r.data);
                  end
               end
            end else if (cyc_q.size() > 0 && cyc_q[0] < cyc) begin
               checks++;
               errors++;
               $display("FAIL up_missing: no pulse by cycle %0d, required one at cycle %0d", cyc, cyc_q[0]);
               void'(cyc_q.pop_front());
               if (resp_q.size() > 0) void'(resp_q.pop_front());
            end
         end
      end
   end

   task automatic finish_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   endtask

   task automatic issue(input logic [31:0] addr, input int len, input int o1, input int o2,
                        input bit ab, input int lat1, input int lat2);
      part_t p1, p2;
      resp_t r;
      int    off, first, b;
      logic [7:0] salt;
      salt  = 8'($urandom);
      off   = int'(addr[3:0]);
      first = (SPLIT && off + len > 16) ? 16 - off : len;
      p1.addr = addr; p1.len = 4'(first); p1.full = 4'(len);
      p1.cpl = 2'($urandom); p1.lock = 1'($urandom); p1.rmw = 1'($urandom);
      p1.outcome = o1; p1.abort = ab; p1.lat = lat1;
      p1.last = ab || o1 != 0 || first == len;
      p1.data = bytes_at(addr, first, salt);
      part_q.push_back(p1);
      if (!p1.last) begin
         p2 = p1;
         p2.addr = addr + 32'(first); p2.len = 4'(len - first);
         p2.outcome = o2; p2.abort = 0; p2.lat = lat2; p2.last = 1;
         p2.data = bytes_at(p2.addr, len - first, salt);
         part_q.push_back(p2);
      end
      if (!ab) begin
         r.kind = (o1 != 0) ? o1 : ((first != len) ? o2 : 0);
         r.data = bytes_at(addr, len, salt);
         resp_q.push_back(r);
      end
      n_issued++;
      tlbread_address = addr; tlbread_length = 4'(len);
      tlbread_cpl = p1.cpl; tlbread_lock = p1.lock; tlbread_rmw = p1.rmw;
      tlbread_do = 1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (dcread_do !== 1'b1) begin
         errors++;
         $display("FAIL dc_do_t1: dcread_do=%b one cycle after accept, required 1", dcread_do);
      end
      if (ab) begin
         rd_reset = 1;
         tlbread_do = 0;
         fork begin @(negedge clk); rd_reset = 0; end join_none
      end
      b = 0;
      do begin @(posedge clk); b++; end while (txn_end_cnt < n_issued && b < 200);
      if (b >= 200) begin
         errors++;
         $display("FAIL txn_timeout: request addr=%h len=%0d did not complete downstream", addr, len);
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $fatal(1);
      end
      @(negedge clk);
      tlbread_do = 0;
      if (!ab) repeat (2) @(negedge clk);
   endtask

   function automatic int pick_outcome();
      int r;
      r = int'($urandom_range(0, 9));
      return (r < 7) ? 0 : r - 6;
   endfunction

   initial begin
      logic [31:0] a, tgt;
      int          len, b;
      part_t       p;
      rst_n = 0; rd_reset = 0; tlbread_do = 0; tlbread_cpl = 0; tlbread_lock = 0;
      tlbread_rmw = 0; tlbread_address = 0; tlbread_length = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({tlbread_done, tlbread_page_fault, tlbread_ac_fault, tlbread_retry, dcread_do} !== 5'b0 ||
          tlbread_data !== 64'd0) begin
         errors++;
         $display("FAIL reset_state: pulses/dc_do=%b data=%h, required 0",
                  {tlbread_done, tlbread_page_fault, tlbread_ac_fault, tlbread_retry, dcread_do}, tlbread_data);
      end
      rst_n = 1;
      repeat (2) @(negedge clk);

      issue(32'h0000_1000, 4, 0, 0, 0, 1, 0);
      issue(32'h0000_100E, 4, 0, 0, 0, 0, 2);
      issue(32'hFFFF_FFFC, 8, 0, 0, 0, 2, 1);
      issue(32'h0000_1008, 8, 0, 0, 0, 0, 0);
      issue(32'h0000_100F, 8, 0, 0, 0, 1, 3);
      issue(32'h0000_100E, 4, 0, 1, 0, 0, 1);
      issue(32'h0000_100E, 4, 1, 0, 0, 2, 0);
      issue(32'h0000_100E, 4, 3, 0, 0, 0, 0);
      issue(32'h0000_100E, 4, 0, 2, 0, 1, 1);
      issue(32'h0000_100E, 4, 0, 0, 1, 2, 0);
      issue(32'h0000_2004, 2, 0, 0, 0, 0, 0);
      issue(32'h0000_100D, 6, 0, 0, 1, 0, 0);
      issue(32'h0000_3000, 1, 0, 0, 0, 0, 0);

      for (int i = 0; i < 80; i++) begin
         a = $urandom;
         if ($urandom_range(0, 7) == 0) a[31:4] = '1;
         len = int'($urandom_range(1, 8));
         issue(a, len, pick_outcome(), pick_outcome(), ($urandom_range(0, 9) == 0),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      // Asynchronous reset while the last part of a split read is outstanding.
      a = 32'h0000_200C;
      tgt = SPLIT ? 32'h0000_2010 : 32'h0000_200C;
      p.addr = a; p.len = SPLIT ? 4'd4 : 4'd8; p.full = 4'd8; p.cpl = 2'd1;
      p.lock = 0; p.rmw = 0; p.outcome = 0; p.abort = 1; p.last = !SPLIT;
      p.lat = SPLIT ? 1 : 40; p.data = bytes_at(a, int'(p.len), 8'h3C);
      part_q.push_back(p);
      if (SPLIT) begin
         p.addr = tgt; p.len = 4'd4; p.last = 1; p.lat = 40;
         p.data = bytes_at(tgt, 4, 8'h3C);
         part_q.push_back(p);
      end
      tlbread_address = a; tlbread_length = 4'd8; tlbread_cpl = 2'd1;
      tlbread_lock = 0; tlbread_rmw = 0; tlbread_do = 1;
      b = 0;
      do begin @(negedge clk); b++; end while (!(dcread_do && dcread_address == tgt) && b < 30);
      checks++;
      if (b >= 30) begin
         errors++;
         $display("FAIL rst_setup: last part addr=%h never requested, dcread_address=%h", tgt, dcread_address);
      end
      #2;
      rst_n = 0;
      tlbread_do = 0;
      #1;
      checks++;
      if ({tlbread_done, tlbread_page_fault, tlbread_ac_fault, tlbread_retry, dcread_do} !== 5'b0 ||
          tlbread_data !== 64'd0) begin
         errors++;
         $display("FAIL async_reset: pulses/dc_do=%b data=%h, required 0",
                  {tlbread_done, tlbread_page_fault, tlbread_ac_fault, tlbread_retry, dcread_do}, tlbread_data);
      end
      part_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1;
      repeat (12) @(negedge clk);

      checks++;
      if (resp_q.size() != 0 || cyc_q.size() != 0 || part_q.size() != 0) begin
         errors++;
         $display("FAIL drain: pending resp=%0d cyc=%0d parts=%0d, required 0/0/0",
                  resp_q.size(), cyc_q.size(), part_q.size());
      end
      finish_run();
   end

endmodule

// File: doc/tlbread_line_split.md
# tlbread_line_split

Splits each read request leaving the memory read stage into at most two 16-byte-line-aligned accesses to the TLB/data-cache read port, then merges the returned bytes into one 64-bit result. It sits directly downstream of the memory read stage, on the `tlbread_*` bus, and upstream of the TLB read engine on the `dcread_*` bus. Keeping line-crossing handling here lets the read stage issue each request as one unsplit access.

## Interface
- No parameters.
- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rd_reset` in 1: pipeline abort from the read stage.
- `tlbread_do` in 1: request valid; upstream holds it high until `done`, fault or retry.
- `tlbread_cpl` in 2, `tlbread_lock` in 1, `tlbread_rmw` in 1: request attributes.
- `tlbread_address` in 32, `tlbread_length` in 4: byte address and length (1..8).
- `tlbread_done` out 1, `tlbread_page_fault` out 1, `tlbread_ac_fault` out 1, `tlbread_retry` out 1: one-cycle completion pulses.
- `tlbread_data` out 64: merged data, little-endian, byte 0 = address byte. Valid with `tlbread_done`.
- `dcread_do` out 1, `dcread_cpl` out 2, `dcread_lock` out 1, `dcread_rmw` out 1: downstream request and attributes.
- `dcread_address` out 32, `dcread_length` out 4, `dcread_length_full` out 4: current part and full length.
- `dcread_done` in 1, `dcread_page_fault` in 1, `dcread_ac_fault` in 1, `dcread_retry` in 1: downstream completion.
- `dcread_data` in 64: part data, LSB = first requested byte.

## Operation
- States: IDLE, FIRST, SECOND, DONE.
- IDLE: on `tlbread_do && !rd_reset`, capture the address, length and attributes. Compute:
  - `left = 16 - addr[3:0]` (5-bit).
  - `len1 = min(length, left)`.
  - `len2 = length - len1`.
  - `addr2 = {addr[31:4],4'd0} + 16` (wraps at 2^32).
  - Go to FIRST.
- FIRST: drive `dcread_do`=1, address = captured address, length = `len1`.
  - On `dcread_done`: store `dcread_data` in a 64-bit buffer. Go to SECOND if `len2 != 0`, else DONE.
- SECOND: drive `dcread_do`=1, address = `addr2`, length = `len2`.
  - On `dcread_done`: merged = buffer bytes [len1-1:0], then `dcread_data` bytes [len2-1:0] placed at byte offset `len1`. Upper bytes are zero.
- DONE: pulse `tlbread_done`, drive the merged/buffered data, return to IDLE.
- `dcread_page_fault` or `dcread_ac_fault` in FIRST or SECOND: pulse the matching `tlbread_*_fault` next cycle, no `done`, return to IDLE. Part 1 results are discarded.
- `dcread_retry` in FIRST or SECOND: pulse `tlbread_retry` next cycle and return to IDLE. Upstream reissues the whole request.
- `rd_reset` while not IDLE: set the `abort` flag. The outstanding part is allowed to finish (done, fault or retry). Then return to IDLE with no `tlbread_*` pulse and no SECOND issue. `abort` clears in IDLE.
- Priority within a cycle: fault > retry > done.
- `dcread_length_full` always carries the captured full length.

## Timing
- Reset values: state=IDLE, all pulses 0, `dcread_do`=0, `tlbread_data`=0, `abort`=0.
- Request accepted in cycle T; `dcread_do` first high in T+1, driven from registers.
- Non-split request: `dcread_done` at cycle D gives `tlbread_done` at D+1.
- Split request: SECOND starts at D1+1; `tlbread_done` at D2+1.
- Fault/retry pulse appears one cycle after the downstream event.
- Upstream keeps `tlbread_do` low during the cycle after a done, fault or retry pulse. The block ignores `tlbread_do` outside IDLE.
- Boundary cases:
  - `addr[3:0]+length == 16` is not split.
  - `addr[3:0]=0xF, length=8` gives `len1=1`, `len2=7`.
  - `addr=0xFFFFFFFC, length=8` gives `addr2=0x00000000`.

## Configuration
- `TLBREAD_LINE_SPLIT_EN` defined: splitting as above.
- Not defined: `len1 = length` and `len2 = 0` always. The request passes through as one access; SECOND and the merge logic are not built. Latency is unchanged (registered request, done at D+1).

## Structure
- Shared package `memory_pkg`: state encoding constants, `LINE_BYTES=16`.
- Sub-module `read_byte_merge`: combinational byte-lane merge.
  - Inputs: buffer, part-2 data, `len1` (1..7), `len2`.
  - Output: 64-bit merged data.
  - Reusable by the write-side splitter.

## Test plan
- Aligned read: addr `0x1000`, len 4, dc data `0x44332211` → one dc access (len 4); `tlbread_done` at D+1 with data `0x44332211`.
- Split read: addr `0x100E`, len 4 → part 1 addr `0x100E` len 2 returns `0xBBAA`; part 2 addr `0x1010` len 2 returns `0xDDCC`; merged data `0xDDCCBBAA`.
- Wrap: addr `0xFFFFFFFC`, len 8 → part 2 address `0x00000000`, len 4.
- Fault on part 2: page fault in SECOND → exactly one `tlbread_page_fault` pulse, no `done`, state returns to IDLE.
- `rd_reset` asserted during FIRST of a split read → part 1 completes, no SECOND access, no upstream pulse; IDLE accepts a new request 1 cycle later.
- `rst_n` asserted low mid-SECOND → all outputs drop to 0 asynchronously; no `done` after release.
